// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter sharing the bridge's single slave port among NUM_MASTERS masters.
// Grant, master index and lock flag are registered and only move on bridge-ready edges.
// Supports locked sequences (with a one-phase lock tail) and a per-tenure beat limit.
module ahb_bus_arbiter #(
   parameter int unsigned NUM_MASTERS    = 2,
   parameter int unsigned DEFAULT_MASTER = 0,
   parameter int unsigned MAX_BEATS      = 16
) (
   input  logic                   Hclk,
   input  logic                   Hreset,
   input  logic [NUM_MASTERS-1:0] Hbusreq,
   input  logic [NUM_MASTERS-1:0] Hlock,
   input  logic [1:0]             Htrans,
   input  logic                   Hreadyout,
   output logic [NUM_MASTERS-1:0] Hgrant,
   output logic [2:0]             Hmaster,
   output logic                   Hmastlock
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] DEF_IDX       = 3'(DEFAULT_MASTER);
   localparam logic [7:0] BEAT_LIMIT    = 8'(MAX_BEATS);

   typedef enum logic [1:0] {StPark, StOwn, StLocked} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [2:0]             rr_ptr_q, rr_ptr_d;
   logic [7:0]             beat_cnt_q, beat_cnt_d;
   logic [2:0]             master_q, master_d;
   logic                   mastlock_q, mastlock_d;

   logic [2:0] win_idx;
   logic       owner_req;
   logic       owner_lock;
   logic       others_req;
   logic       any_req;
   logic       is_beat;
   logic       burst_start;

   // Index to one-hot grant vector.
   function automatic logic [NUM_MASTERS-1:0] onehot(input logic [2:0] idx);
      logic [NUM_MASTERS-1:0] oh;
      oh = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         oh[i] = (32'(idx) == i);
      end
      return oh;
   endfunction

   // Scan requests from ptr+1 upward with wrap; ptr itself is examined last.
   function automatic logic [2:0] rr_winner(input logic [2:0]             ptr,
                                            input logic [NUM_MASTERS-1:0] req);
      logic [2:0]             win;
      logic                   found;
      int unsigned            cand;
      logic [NUM_MASTERS-1:0] shifted;
      win   = ptr;
      found = 1'b0;
      for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
         cand    = (32'(ptr) + k) % NUM_MASTERS;
         shifted = req >> cand;
         if (!found && shifted[0]) begin
            win   = cand[2:0];
            found = 1'b1;
         end
      end
      return win;
   endfunction

   // rr_ptr always tracks the granted index, so the owner is found through grant_q.
   always_comb begin
      owner_req   = |(Hbusreq & grant_q);
      owner_lock  = |(Hlock & grant_q);
      others_req  = |(Hbusreq & ~grant_q);
      any_req     = |Hbusreq;
      is_beat     = Htrans[1];
      burst_start = (Htrans == HTRANS_IDLE) || (Htrans == HTRANS_NONSEQ);
      win_idx     = rr_winner(rr_ptr_q, Hbusreq);
   end

   // Next-state: arbitration, lock handling and beat accounting on ready edges only.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      master_d   = master_q;
      mastlock_d = mastlock_q;

      if (Hreadyout) begin
         // Address-phase owner lags the grant by one ready edge.
         master_d   = rr_ptr_q;
         mastlock_d = owner_lock;
         if (is_beat && (beat_cnt_q < BEAT_LIMIT)) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
         end

         unique case (state_q)
            StPark: begin
               beat_cnt_d = '0;
               if (any_req) begin
                  state_d  = StOwn;
                  grant_d  = onehot(win_idx);
                  rr_ptr_d = win_idx;
               end
            end

            StOwn: begin
               if (owner_req && owner_lock) begin
                  state_d = StLocked;
               end else if (!owner_req) begin
                  beat_cnt_d = '0;
                  if (any_req) begin
                     grant_d  = onehot(win_idx);
                     rr_ptr_d = win_idx;
                  end else begin
                     state_d  = StPark;
                     grant_d  = onehot(DEF_IDX);
                     rr_ptr_d = DEF_IDX;
                  end
               end else if (beat_cnt_q == BEAT_LIMIT) begin
                  if (!others_req) begin
                     beat_cnt_d = '0;
                  end else if (burst_start) begin
                     // Only cut the tenure at a burst boundary, never on SEQ/BUSY.
                     beat_cnt_d = '0;
                     grant_d    = onehot(win_idx);
                     rr_ptr_d   = win_idx;
                  end
               end
            end

            StLocked: begin
               // Grant and beat count frozen; lock release gives one tail phase in StOwn.
               beat_cnt_d = beat_cnt_q;
               if (!owner_lock) begin
                  state_d = StOwn;
               end
            end

            default: begin
               state_d    = StPark;
               grant_d    = onehot(DEF_IDX);
               rr_ptr_d   = DEF_IDX;
               beat_cnt_d = '0;
            end
         endcase
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         state_q    <= StPark;
         grant_q    <= onehot(DEF_IDX);
         rr_ptr_q   <= DEF_IDX;
         beat_cnt_q <= '0;
         master_q   <= DEF_IDX;
         mastlock_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         master_q   <= master_d;
         mastlock_q <= mastlock_d;
      end
   end

   assign Hgrant    = grant_q;
   assign Hmaster   = master_q;
   assign Hmastlock = mastlock_q;

   // Structural invariants of the grant outputs.
   grant_onehot_a : assert property (@(posedge Hclk) disable iff (Hreset) $onehot(grant_q));
   master_range_a : assert property (@(posedge Hclk) disable iff (Hreset)
                                     32'(master_q) < NUM_MASTERS);

endmodule
